// File: rtl/lii_pkg.sv
// lii_pkg -- shared constants and types for the LII output arbiter.
//   LII_ID_W    : width of source/destination IDs on the phy link
//   GID_W       : width of a requester index (grant_id, last_grant)
//   arb_state_e : arbiter FSM state (IDLE, GRANT)
package lii_pkg;
  localparam int LII_ID_W = 8;
  localparam int GID_W    = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter -- combinational round-robin picker.
//   req    [N-1:0] : requests
//   last   [3:0]   : index of the previous grant holder (must be < N)
//   onehot [N-1:0] : selected requester, one-hot (all zero when no request)
//   index  [3:0]   : selected requester index (0 when no request)
// The search starts at (last+1) mod N and wraps, so the previous holder
// is considered last.
module rr_arbiter
  import lii_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [GID_W-1:0] last,
  output logic [N-1:0]     onehot,
  output logic [GID_W-1:0] index
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [5:0] cand;
  logic       found;

  always_comb begin
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {2'b00, last} + 6'(k);
      if (cand >= 6'(N)) cand = cand - 6'(N);
      if (!found && req[cand[IW-1:0]]) begin
        found                  = 1'b1;
        onehot[cand[IW-1:0]]   = 1'b1;
        index                  = GID_W'(cand);
      end
    end
  end
endmodule

// File: rtl/lii_out_arbiter.sv
// lii_out_arbiter -- round-robin merge of N requester streams onto one
// LII phy output, with bounded bursts and a one-entry output register.
//   aclk, arstn       : clock, async active-low reset
//   req_tdata/tvalid/tready/dst : N requester streams (slice i = requester i)
//   lii_out_p0_tdata/tvalid/tready : phy output stream
//   lii_out_p0_src    : constant SRC_ID
//   lii_out_p0_dst    : destination ID captured with each beat
//   grant_id          : current grant holder (meaningful in GRANT)
//   stat_beats        : per-requester 32-bit transferred-beat counters
// Build option: define LII_ARB_STATS_EN to build the stat_beats counters;
// otherwise stat_beats is tied to zero.
module lii_out_arbiter
  import lii_pkg::*;
#(
  parameter int            N      = 4,
  parameter int            PW     = 128,
  parameter int            BURST  = 16,
  parameter logic [7:0]    SRC_ID = 8'h00
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic [N*PW-1:0]       req_tdata,
  input  logic [N-1:0]          req_tvalid,
  output logic [N-1:0]          req_tready,
  input  logic [N*8-1:0]        req_dst,
  output logic [PW-1:0]         lii_out_p0_tdata,
  output logic                  lii_out_p0_tvalid,
  input  logic                  lii_out_p0_tready,
  output logic [LII_ID_W-1:0]   lii_out_p0_src,
  output logic [LII_ID_W-1:0]   lii_out_p0_dst,
  output logic [GID_W-1:0]      grant_id,
  output logic [N*32-1:0]       stat_beats
);
  arb_state_e          state_q, state_d;
  logic [GID_W-1:0]    gnt_q, last_q;
  logic [8:0]          beat_q;
  logic [N-1:0]        arb_oh, gnt_oh;
  logic [GID_W-1:0]    arb_idx;

  logic                out_vld_q;
  logic [PW-1:0]       out_data_q;
  logic [LII_ID_W-1:0] out_dst_q;

  logic                out_ready, cur_vld, xfer, last_beat;
  logic [PW-1:0]       cur_data;
  logic [LII_ID_W-1:0] cur_dst;

  rr_arbiter #(.N(N)) u_rr (
    .req    (req_tvalid),
    .last   (last_q),
    .onehot (arb_oh),
    .index  (arb_idx)
  );

  // Grant holder decode and its stream mux.
  always_comb begin
    gnt_oh   = '0;
    cur_vld  = 1'b0;
    cur_data = '0;
    cur_dst  = '0;
    for (int i = 0; i < N; i++) begin
      gnt_oh[i] = (gnt_q == GID_W'(i));
      if (gnt_oh[i]) begin
        cur_vld  = req_tvalid[i];
        cur_data = req_tdata[i*PW +: PW];
        cur_dst  = req_dst[i*8 +: 8];
      end
    end
  end

  // Output register accepts a new beat when empty or draining this cycle,
  // which gives full throughput without a skid buffer.
  assign out_ready  = !out_vld_q | lii_out_p0_tready;
  assign xfer       = (state_q == GRANT) & cur_vld & out_ready;
  assign last_beat  = (beat_q == 9'(BURST - 1));
  assign req_tready = ((state_q == GRANT) && out_ready) ? gnt_oh : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|arb_oh) state_d = GRANT;
      GRANT: begin
        if (!cur_vld)               state_d = IDLE;
        else if (xfer && last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= GID_W'(N - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (|arb_oh)) gnt_q <= arb_idx;
      // Leaving GRANT closes the burst; the mandatory IDLE cycle re-arbitrates.
      if (state_q == GRANT && state_d == IDLE) begin
        last_q <= gnt_q;
        beat_q <= '0;
      end else if (xfer) begin
        beat_q <= beat_q + 9'd1;
      end
    end
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_dst_q  <= '0;
    end else if (out_ready) begin
      out_vld_q <= xfer;
      if (xfer) begin
        out_data_q <= cur_data;
        out_dst_q  <= cur_dst;
      end
    end
  end

  assign lii_out_p0_tvalid = out_vld_q;
  assign lii_out_p0_tdata  = out_data_q;
  assign lii_out_p0_dst    = out_dst_q;
  assign lii_out_p0_src    = SRC_ID;
  assign grant_id          = gnt_q;

`ifdef LII_ARB_STATS_EN
  for (genvar i = 0; i < N; i++) begin : g_stat
    logic [31:0] cnt_q;
    always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn)                cnt_q <= '0;
      else if (xfer && gnt_oh[i]) cnt_q <= cnt_q + 32'd1;
    end
    assign stat_beats[i*32 +: 32] = cnt_q;
  end
`else
  assign stat_beats = '0;
`endif
endmodule

// File: doc/lii_out_arbiter.md
LII_OUT_ARBITER -- requirements
Module: lii_out_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of logical requester streams (2..16).
REQ-002 SHALL have parameter PW, default 128: packing width of each beat.
REQ-003 SHALL have parameter BURST, default 16: maximum beats per grant (1..256).
REQ-004 SHALL have parameter SRC_ID, default 8'h00: value driven on lii_out_p0_src.
REQ-005 SHALL have port aclk, input, 1 bit: single clock for all logic.
REQ-006 SHALL have port arstn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port req_tdata, input, N*PW bits: requester i data at slice [i*PW +: PW].
REQ-008 SHALL have port req_tvalid, input, N bits: per-requester valid.
REQ-009 SHALL have port req_tready, output, N bits: per-requester ready.
REQ-010 SHALL have port req_dst, input, N*8 bits: requester i destination ID at [i*8 +: 8].
REQ-011 SHALL have port lii_out_p0_tdata, output, PW bits: phy output data.
REQ-012 SHALL have port lii_out_p0_tvalid, output, 1 bit: phy output valid.
REQ-013 SHALL have port lii_out_p0_tready, input, 1 bit: phy output ready.
REQ-014 SHALL have port lii_out_p0_src, output, 8 bits: source ID, constant SRC_ID.
REQ-015 SHALL have port lii_out_p0_dst, output, 8 bits: destination ID captured with the beat.
REQ-016 SHALL have port grant_id, output, 4 bits: index of the current grant holder; valid in GRANT.
REQ-017 SHALL have port stat_beats, output, N*32 bits: per-requester count of transferred beats.

Function
REQ-018 SHALL implement FSM states IDLE and GRANT.
REQ-019 In IDLE, when any req_tvalid is high, SHALL select the first requester with tvalid high, searching from (last_grant+1) mod N upward with wrap-around, and enter GRANT next cycle.
REQ-020 In IDLE, SHALL hold every req_tready bit low.
REQ-021 SHALL hold a one-entry output register (valid, data, dst); it loads when empty or when lii_out_p0_tready is high.
REQ-022 In GRANT, req_tready[g] SHALL equal (!lii_out_p0_tvalid | lii_out_p0_tready); all other req_tready bits SHALL be low.
REQ-023 A beat transfers when req_tvalid[g] & req_tready[g]; it SHALL appear on lii_out_p0_* exactly 1 cycle later, together with req_dst of g.
REQ-024 Data on the phy output SHALL be held stable while lii_out_p0_tvalid=1 & lii_out_p0_tready=0.
REQ-025 A beat counter SHALL count transfers within a grant and SHALL return to IDLE after the BURST-th transfer.
REQ-026 SHALL return to IDLE when req_tvalid[g] is low in a GRANT cycle.
REQ-027 On every return to IDLE, SHALL update last_grant := g and clear the beat counter; one idle cycle SHALL separate grants.
REQ-028 When the output register drains and loads in the same cycle, SHALL lose no beat and duplicate no beat (full throughput).
REQ-029 lii_out_p0_src SHALL equal SRC_ID at all times.

Reset
REQ-030 On arstn low, SHALL immediately enter IDLE and clear lii_out_p0_tvalid, lii_out_p0_tdata, lii_out_p0_dst, the beat counter and stat_beats; last_grant SHALL be set to N-1 (first arbitration favours requester 0); grant_id SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL discard the held beat; after release the block SHALL start in IDLE.

Configuration
REQ-032 With LII_ARB_STATS_EN defined, stat_beats[i] SHALL increment by 1 on each requester-i transfer, as a 32-bit counter wrapping at 2^32.
REQ-033 Without LII_ARB_STATS_EN, stat_beats SHALL be tied to 0 and no counter logic SHALL be built.

Structure
REQ-034 Package lii_pkg SHALL hold LII_ID_W=8 and the FSM state typedef (IDLE, GRANT).
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_arbiter(N): inputs req and last, outputs onehot and index.

Verification
REQ-036 Reset, then req_tvalid=4'b0001 with 3 beats -> 3 beats out with dst=req_dst[0], 1 cycle latency; lii_out_p0_src=SRC_ID.
REQ-037 All 4 requesters continuously valid, BURST=4 -> grants in order 0,1,2,3,0, each 4 beats, one idle cycle between grants.
REQ-038 lii_out_p0_tready low for 5 cycles mid-burst -> tdata stable, req_tready[g] low, no beat lost, sequence intact.
REQ-039 Requester 2 drops tvalid after 2 of 16 beats -> IDLE, then the next valid requester above 2 is granted.
REQ-040 arstn pulsed low mid-burst -> lii_out_p0_tvalid=0 immediately; after release, first grant goes to requester 0.
REQ-041 With LII_ARB_STATS_EN, 10 beats from requester 1 -> stat_beats[1]=10 and all others 0; without the macro, stat_beats=0.
